multicycle_maindec: RTL and testbench

Main control FSM for the multicycle MIPS datapath. It is the sequential successor to the single-cycle/pipelined main decoder. It steps each instruction through fetch, decode, execute, memory and writeback states, and drives the datapath mux selects and write strobes from the current state. Over the current decoder it adds optional extended immediates (ANDI, ORI, BNE), a memory-ready handshake, and sticky illegal-opcode reporting.

---
 rtl/multicycle_maindec.sv | 211 +++++++++++++++++++++
 tb/tb_multicycle_maindec.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_maindec.sv
// Main control FSM for the multicycle MIPS datapath: sequences each instruction
// through fetch/decode/execute/memory/writeback and drives datapath controls.
module multicycle_maindec #(
    parameter int EXT_OPS       = 1,
    parameter int MEM_HANDSHAKE = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       branch,
    output logic       branch_ne,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       logic_or,
    output logic       imm_zext,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_IMMEX   = 4'd9,
        S_IMMWB   = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic EXT = (EXT_OPS != 0);
    localparam logic HS  = (MEM_HANDSHAKE != 0);

    state_t cur_state;
    state_t next_state;
    logic   illegal_q;
    logic   illegal_set;
    logic   mem_ok;

    logic   is_rtype, is_lw, is_sw, is_beq, is_bne;
    logic   is_addi, is_andi, is_ori, is_j;

    logic   pcwrite_s, branch_s, branch_ne_s, irwrite_s, memwrite_s, regwrite_s;

    assign mem_ok = HS ? mem_ready : 1'b1;

    assign is_rtype = (op == OP_RTYPE);
    assign is_lw    = (op == OP_LW);
    assign is_sw    = (op == OP_SW);
    assign is_beq   = (op == OP_BEQ);
    assign is_bne   = EXT && (op == OP_BNE);
    assign is_addi  = (op == OP_ADDI);
    assign is_andi  = EXT && (op == OP_ANDI);
    assign is_ori   = EXT && (op == OP_ORI);
    assign is_j     = (op == OP_J);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_state <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            cur_state <= next_state;
            if (illegal_set) begin
                illegal_q <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state  = S_FETCH;
        illegal_set = 1'b0;
        pcwrite_s   = 1'b0;
        branch_s    = 1'b0;
        branch_ne_s = 1'b0;
        irwrite_s   = 1'b0;
        memwrite_s  = 1'b0;
        regwrite_s  = 1'b0;
        iord        = 1'b0;
        memtoreg    = 1'b0;
        regdst      = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        pcsrc       = 2'b00;
        aluop       = 2'b00;
        logic_or    = 1'b0;
        imm_zext    = 1'b0;

        case (cur_state)
            S_FETCH: begin
                alusrcb    = 2'b01;
                irwrite_s  = mem_ok;
                pcwrite_s  = mem_ok;
                next_state = mem_ok ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Branch target is precomputed into ALUOut while the opcode resolves.
                alusrcb = 2'b11;
                if (is_rtype) begin
                    next_state = S_EXECUTE;
                end else if (is_lw || is_sw) begin
                    next_state = S_MEMADR;
                end else if (is_beq || is_bne) begin
                    next_state = S_BRANCH;
                end else if (is_addi || is_andi || is_ori) begin
                    next_state = S_IMMEX;
                end else if (is_j) begin
                    next_state = S_JUMP;
                end else begin
                    next_state  = S_FETCH;
                    illegal_set = 1'b1;
                end
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                next_state = is_sw ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord       = 1'b1;
                next_state = mem_ok ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                regwrite_s = 1'b1;
                memtoreg   = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWR: begin
                // memwrite stays up for the whole wait so the memory sees a stable request.
                iord       = 1'b1;
                memwrite_s = 1'b1;
                next_state = mem_ok ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                alusrca    = 1'b1;
                aluop      = 2'b10;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                regwrite_s = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                alusrca     = 1'b1;
                aluop       = 2'b01;
                pcsrc       = 2'b01;
                branch_s    = is_beq;
                branch_ne_s = is_bne;
                next_state  = S_FETCH;
            end
            S_IMMEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                if (is_andi || is_ori) begin
                    aluop    = 2'b11;
                    imm_zext = 1'b1;
                    logic_or = op[0];
                end
                next_state = S_IMMWB;
            end
            S_IMMWB: begin
                regwrite_s = 1'b1;
                next_state = S_FETCH;
            end
            S_JUMP: begin
                pcsrc      = 2'b10;
                pcwrite_s  = 1'b1;
                next_state = S_FETCH;
            end
            default: begin
                next_state = S_FETCH;
            end
        endcase
    end

    // Strobes are gated by reset_n so they fall asynchronously with the reset.
    assign pcwrite    = pcwrite_s   & reset_n;
    assign branch     = branch_s    & reset_n;
    assign branch_ne  = branch_ne_s & reset_n;
    assign irwrite    = irwrite_s   & reset_n;
    assign memwrite   = memwrite_s  & reset_n;
    assign regwrite   = regwrite_s  & reset_n;

    assign illegal_op = illegal_q;
    assign state      = cur_state;

endmodule

// File: tb/tb_multicycle_maindec.sv
// Directed, table-driven bench for multicycle_maindec: per-cycle state and
// control-vector checks plus stall, illegal-opcode and async-reset sequences.
module tb_multicycle_maindec;

    logic       clk;
    logic       reset_n;
    logic [5:0] op;
    logic       mem_ready;

    logic       pcwrite, branch, branch_ne, irwrite, memwrite, regwrite;
    logic       iord, memtoreg, regdst, alusrca, logic_or, imm_zext, illegal_op;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic [3:0] state;

    logic       pcwrite0, branch0, branch_ne0, irwrite0, memwrite0, regwrite0;
    logic       iord0, memtoreg0, regdst0, alusrca0, logic_or0, imm_zext0, illegal_op0;
    logic [1:0] alusrcb0, pcsrc0, aluop0;
    logic [3:0] state0;

    logic [17:0] outs, outs0;

    int n_chk  = 0;
    int n_fail = 0;
    logic exp_ill;

    multicycle_maindec #(.EXT_OPS(1), .MEM_HANDSHAKE(1)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .branch(branch), .branch_ne(branch_ne), .irwrite(irwrite),
        .memwrite(memwrite), .regwrite(regwrite), .iord(iord), .memtoreg(memtoreg),
        .regdst(regdst), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .aluop(aluop), .logic_or(logic_or), .imm_zext(imm_zext),
        .illegal_op(illegal_op), .state(state)
    );

    multicycle_maindec #(.EXT_OPS(0), .MEM_HANDSHAKE(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
        .pcwrite(pcwrite0), .branch(branch0), .branch_ne(branch_ne0), .irwrite(irwrite0),
        .memwrite(memwrite0), .regwrite(regwrite0), .iord(iord0), .memtoreg(memtoreg0),
        .regdst(regdst0), .alusrca(alusrca0), .alusrcb(alusrcb0), .pcsrc(pcsrc0),
        .aluop(aluop0), .logic_or(logic_or0), .imm_zext(imm_zext0),
        .illegal_op(illegal_op0), .state(state0)
    );

    assign outs  = {pcwrite, branch, branch_ne, irwrite, memwrite, regwrite, iord, memtoreg,
                    regdst, alusrca, alusrcb, pcsrc, aluop, logic_or, imm_zext};
    assign outs0 = {pcwrite0, branch0, branch_ne0, irwrite0, memwrite0, regwrite0, iord0, memtoreg0,
                    regdst0, alusrca0, alusrcb0, pcsrc0, aluop0, logic_or0, imm_zext0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Field order: pcw br bne irw memw regw iord m2r rdst asa asb pcsrc aluop or zext
    localparam logic [17:0] O_F1   = 18'b1_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
    localparam logic [17:0] O_F0   = 18'b0_0_0_0_0_0_0_0_0_0_01_00_00_0_0;
    localparam logic [17:0] O_DEC  = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
    localparam logic [17:0] O_MA   = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [17:0] O_MRD  = 18'b0_0_0_0_0_0_1_0_0_0_00_00_00_0_0;
    localparam logic [17:0] O_MWB  = 18'b0_0_0_0_0_1_0_1_0_0_00_00_00_0_0;
    localparam logic [17:0] O_MWR  = 18'b0_0_0_0_1_0_1_0_0_0_00_00_00_0_0;
    localparam logic [17:0] O_EXE  = 18'b0_0_0_0_0_0_0_0_0_1_00_00_10_0_0;
    localparam logic [17:0] O_AWB  = 18'b0_0_0_0_0_1_0_0_1_0_00_00_00_0_0;
    localparam logic [17:0] O_BEQ  = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_0_0;
    localparam logic [17:0] O_BNE  = 18'b0_0_1_0_0_0_0_0_0_1_00_01_01_0_0;
    localparam logic [17:0] O_ADDX = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [17:0] O_ANDX = 18'b0_0_0_0_0_0_0_0_0_1_10_00_11_0_1;
    localparam logic [17:0] O_ORX  = 18'b0_0_0_0_0_0_0_0_0_1_10_00_11_1_1;
    localparam logic [17:0] O_IWB  = 18'b0_0_0_0_0_1_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] O_JMP  = 18'b1_0_0_0_0_0_0_0_0_0_00_10_00_0_0;
    localparam logic [17:0] OZ     = 18'd0;
    localparam logic [3:0]  Z      = 4'd0;

    typedef struct packed {
        logic [5:0]        op;
        logic [3:0]        len;
        logic [0:7][3:0]   st;
        logic [0:7][17:0]  ex;
    } vec_t;

    vec_t  vecs [9];
    string names [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic mr, input logic [3:0] st, input logic [17:0] ex, input string nm);
        mem_ready = mr;
        #1;
        chk({nm, " state"}, 32'(state), 32'(st));
        chk({nm, " outs"}, 32'(outs), 32'(ex));
        chk({nm, " illegal_op"}, 32'(illegal_op), 32'(exp_ill));
        @(negedge clk);
    endtask

    task automatic run_row(input int k);
        op = vecs[k].op;
        for (int i = 0; i < int'(vecs[k].len); i++) begin
            step(1'b1, vecs[k].st[i], vecs[k].ex[i], $sformatf("%s c%0d", names[k], i));
        end
    endtask

    initial begin
        vecs[0] = '{6'b000000, 4'd4, {4'd0, 4'd1, 4'd6, 4'd7, Z, Z, Z, Z},
                    {O_F1, O_DEC, O_EXE, O_AWB, OZ, OZ, OZ, OZ}};
        names[0] = "rtype";
        vecs[1] = '{6'b100011, 4'd5, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, Z, Z, Z},
                    {O_F1, O_DEC, O_MA, O_MRD, O_MWB, OZ, OZ, OZ}};
        names[1] = "lw";
        vecs[2] = '{6'b101011, 4'd4, {4'd0, 4'd1, 4'd2, 4'd5, Z, Z, Z, Z},
                    {O_F1, O_DEC, O_MA, O_MWR, OZ, OZ, OZ, OZ}};
        names[2] = "sw";
        vecs[3] = '{6'b000100, 4'd3, {4'd0, 4'd1, 4'd8, Z, Z, Z, Z, Z},
                    {O_F1, O_DEC, O_BEQ, OZ, OZ, OZ, OZ, OZ}};
        names[3] = "beq";
        vecs[4] = '{6'b000101, 4'd3, {4'd0, 4'd1, 4'd8, Z, Z, Z, Z, Z},
                    {O_F1, O_DEC, O_BNE, OZ, OZ, OZ, OZ, OZ}};
        names[4] = "bne";
        vecs[5] = '{6'b001000, 4'd4, {4'd0, 4'd1, 4'd9, 4'd10, Z, Z, Z, Z},
                    {O_F1, O_DEC, O_ADDX, O_IWB, OZ, OZ, OZ, OZ}};
        names[5] = "addi";
        vecs[6] = '{6'b001100, 4'd4, {4'd0, 4'd1, 4'd9, 4'd10, Z, Z, Z, Z},
                    {O_F1, O_DEC, O_ANDX, O_IWB, OZ, OZ, OZ, OZ}};
        names[6] = "andi";
        vecs[7] = '{6'b001101, 4'd4, {4'd0, 4'd1, 4'd9, 4'd10, Z, Z, Z, Z},
                    {O_F1, O_DEC, O_ORX, O_IWB, OZ, OZ, OZ, OZ}};
        names[7] = "ori";
        vecs[8] = '{6'b000010, 4'd3, {4'd0, 4'd1, 4'd11, Z, Z, Z, Z, Z},
                    {O_F1, O_DEC, O_JMP, OZ, OZ, OZ, OZ, OZ}};
        names[8] = "j";

        // Reset held: FETCH, strobes forced low even though mem_ready=1
        reset_n   = 1'b0;
        op        = 6'b000000;
        mem_ready = 1'b1;
        exp_ill   = 1'b0;
        #12;
        chk("reset state", 32'(state), 32'd0);
        chk("reset outs", 32'(outs), 32'(O_F0));
        chk("reset illegal_op", 32'(illegal_op), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // ORI on both builds: legal with EXT_OPS=1, illegal with EXT_OPS=0
        op = 6'b001101;
        #1;
        chk("ext0 ori c0 state", 32'(state0), 32'd0);
        chk("ext0 ori c0 outs", 32'(outs0), 32'(O_F1));
        step(1'b1, 4'd0, O_F1, "ori c0");
        #1;
        chk("ext0 ori c1 state", 32'(state0), 32'd1);
        chk("ext0 ori c1 outs", 32'(outs0), 32'(O_DEC));
        chk("ext0 ori c1 illegal", 32'(illegal_op0), 32'd0);
        step(1'b1, 4'd1, O_DEC, "ori c1");
        #1;
        chk("ext0 ori c2 state", 32'(state0), 32'd0);
        chk("ext0 ori c2 illegal", 32'(illegal_op0), 32'd1);
        step(1'b1, 4'd9, O_ORX, "ori c2");
        step(1'b1, 4'd10, O_IWB, "ori c3");

        // Every instruction class with mem_ready tied high
        for (int k = 0; k < 9; k++) begin
            run_row(k);
        end

        // LW with two wait cycles in MEMRD
        op = 6'b100011;
        step(1'b1, 4'd0, O_F1, "lwst c0");
        step(1'b1, 4'd1, O_DEC, "lwst c1");
        step(1'b1, 4'd2, O_MA, "lwst c2");
        step(1'b0, 4'd3, O_MRD, "lwst c3");
        step(1'b0, 4'd3, O_MRD, "lwst c4");
        step(1'b1, 4'd3, O_MRD, "lwst c5");
        step(1'b1, 4'd4, O_MWB, "lwst c6");

        // SW with three wait cycles in MEMWR: memwrite held four cycles
        op = 6'b101011;
        step(1'b1, 4'd0, O_F1, "swst c0");
        step(1'b1, 4'd1, O_DEC, "swst c1");
        step(1'b1, 4'd2, O_MA, "swst c2");
        step(1'b0, 4'd5, O_MWR, "swst c3");
        step(1'b0, 4'd5, O_MWR, "swst c4");
        step(1'b0, 4'd5, O_MWR, "swst c5");
        step(1'b1, 4'd5, O_MWR, "swst c6");

        // J with a two-cycle fetch stall: no pc/ir write until mem_ready
        op = 6'b000010;
        step(1'b0, 4'd0, O_F0, "jst c0");
        step(1'b0, 4'd0, O_F0, "jst c1");
        step(1'b1, 4'd0, O_F1, "jst c2");
        step(1'b1, 4'd1, O_DEC, "jst c3");
        step(1'b1, 4'd11, O_JMP, "jst c4");

        // Illegal opcode: sticky across later legal instructions
        op = 6'b111111;
        step(1'b1, 4'd0, O_F1, "ill c0");
        step(1'b1, 4'd1, O_DEC, "ill c1");
        exp_ill = 1'b1;
        run_row(0);
        run_row(3);

        // Async reset while memwrite is held in MEMWR
        op = 6'b101011;
        step(1'b1, 4'd0, O_F1, "rst c0");
        step(1'b1, 4'd1, O_DEC, "rst c1");
        step(1'b1, 4'd2, O_MA, "rst c2");
        mem_ready = 1'b0;
        #2;
        chk("pre-reset state", 32'(state), 32'd5);
        chk("pre-reset memwrite", 32'(memwrite), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("async reset memwrite", 32'(memwrite), 32'd0);
        chk("async reset state", 32'(state), 32'd0);
        chk("async reset illegal_op", 32'(illegal_op), 32'd0);
        exp_ill = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        run_row(0);
        run_row(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
